argmax_stream: RTL

- Parametrised streaming argmax unit that replaces the fixed 10-input, 64-bit classifier argmax.
- Accepts NUM_CLASSES signed scores, one per handshake beat, from the final dense-layer accumulator of the CNN accelerator.
- Returns the winning class index and its score to the RISC-V SoC result register through a held valid/ready result port.
- Adds frame framing, a length-error flag and back-pressure, which the fixed-width predecessor lacks.

---
 rtl/argmax_pkg.sv | 19 +
 rtl/argmax_cmp.sv | 54 +++++
 rtl/argmax_stream.sv | 137 +++++++++++++
 3 files changed

// File: rtl/argmax_pkg.sv
// Shared types and constants for the streaming argmax unit.
// ARGMAX_MARGIN_EN (optional) adds runner-up score and margin outputs.
package argmax_pkg;

  localparam int NUM_CLASSES_DEF = 10;
  localparam int DATA_W_DEF      = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } argmax_state_t;

  // Class index width; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/argmax_cmp.sv
// Combinational signed compare/select of a candidate score against the running max.
// With ARGMAX_MARGIN_EN the runner-up score is tracked as well.
module argmax_cmp #(
  parameter int DATA_W = 64,
  parameter int IDX_W  = 4
) (
  input  logic                     i_first,
  input  logic signed [DATA_W-1:0] i_cand,
  input  logic [IDX_W-1:0]         i_cand_idx,
  input  logic signed [DATA_W-1:0] i_cur_max,
  input  logic [IDX_W-1:0]         i_cur_idx,
`ifdef ARGMAX_MARGIN_EN
  input  logic signed [DATA_W-1:0] i_cur_sec,
  input  logic                     i_sec_vld,
  output logic signed [DATA_W-1:0] o_nxt_sec,
  output logic                     o_nxt_sec_vld,
`endif
  output logic signed [DATA_W-1:0] o_nxt_max,
  output logic [IDX_W-1:0]         o_nxt_idx
);

  logic w_gt;
  // Strict compare: ties keep the lower index already held.
  assign w_gt = i_cand > i_cur_max;

  always_comb begin
    o_nxt_max = i_cur_max;
    o_nxt_idx = i_cur_idx;
    if (i_first) begin
      o_nxt_max = i_cand;
      o_nxt_idx = '0;
    end else if (w_gt) begin
      o_nxt_max = i_cand;
      o_nxt_idx = i_cand_idx;
    end
  end

`ifdef ARGMAX_MARGIN_EN
  // Runner-up mirrors the max after one beat so a single-beat frame has zero margin.
  always_comb begin
    o_nxt_sec     = i_cur_sec;
    o_nxt_sec_vld = 1'b1;
    if (i_first) begin
      o_nxt_sec     = i_cand;
      o_nxt_sec_vld = 1'b0;
    end else if (w_gt) begin
      o_nxt_sec = i_cur_max;
    end else if (!i_sec_vld || (i_cand > i_cur_sec)) begin
      o_nxt_sec = i_cand;
    end
  end
`endif

endmodule

// File: rtl/argmax_stream.sv
// Streaming argmax over NUM_CLASSES signed scores with a held valid/ready result port.
// Optional macro ARGMAX_MARGIN_EN adds second_val and margin outputs.
module argmax_stream
  import argmax_pkg::*;
#(
  parameter  int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter  int DATA_W      = DATA_W_DEF,
  localparam int IDX_W       = idx_w(NUM_CLASSES)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDX_W-1:0]  max_index,
  output logic [DATA_W-1:0] max_val,
  output logic              len_err,
`ifdef ARGMAX_MARGIN_EN
  output logic [DATA_W-1:0] second_val,
  output logic [DATA_W:0]   margin,
`endif
  output logic              busy
);

  // One spare count bit so the counter can step past NUM_CLASSES-1 without wrapping.
  localparam int               CNT_W    = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CLASSES - 1);

  argmax_state_t     r_state, w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx, w_nidx;
  logic [DATA_W-1:0] r_max, w_nmax;
  logic              r_len_err, r_res_valid;
  logic              w_acc, w_first, w_cnt_end, w_end;
`ifdef ARGMAX_MARGIN_EN
  logic [DATA_W-1:0] r_sec, w_nsec;
  logic              r_sec_vld, w_nsec_vld;
  logic [DATA_W:0]   r_margin;
`endif

  assign w_acc     = s_valid && (r_state == SCAN);
  assign w_first   = (r_cnt == '0);
  assign w_cnt_end = (r_cnt == LAST_CNT);
  assign w_end     = w_acc && (s_last || w_cnt_end);

  argmax_cmp #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_cmp (
    .i_first       (w_first),
    .i_cand        (s_data),
    .i_cand_idx    (r_cnt[IDX_W-1:0]),
    .i_cur_max     (r_max),
    .i_cur_idx     (r_idx),
`ifdef ARGMAX_MARGIN_EN
    .i_cur_sec     (r_sec),
    .i_sec_vld     (r_sec_vld),
    .o_nxt_sec     (w_nsec),
    .o_nxt_sec_vld (w_nsec_vld),
`endif
    .o_nxt_max     (w_nmax),
    .o_nxt_idx     (w_nidx)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start)     w_next = SCAN;
      SCAN:    if (w_end)     w_next = DONE;
      DONE:    if (res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    s_ready = (r_state == SCAN);
    busy    = (r_state != IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_max       <= '0;
      r_len_err   <= 1'b0;
      r_res_valid <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
      r_sec       <= '0;
      r_sec_vld   <= 1'b0;
      r_margin    <= '0;
`endif
    end else begin
      unique case (r_state)
        IDLE: if (start) begin
          r_cnt       <= '0;
          r_len_err   <= 1'b0;
          r_res_valid <= 1'b0;
        end
        SCAN: if (w_acc) begin
          r_cnt <= r_cnt + CNT_W'(1);
          r_max <= w_nmax;
          r_idx <= w_nidx;
`ifdef ARGMAX_MARGIN_EN
          r_sec     <= w_nsec;
          r_sec_vld <= w_nsec_vld;
`endif
          if (w_end) begin
            r_res_valid <= 1'b1;
            // Early s_last or a missing s_last on the final beat both flag the frame.
            r_len_err   <= s_last ^ w_cnt_end;
`ifdef ARGMAX_MARGIN_EN
            r_margin    <= {w_nmax[DATA_W-1], w_nmax} - {w_nsec[DATA_W-1], w_nsec};
`endif
          end
        end
        DONE: if (res_ready) r_res_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign res_valid = r_res_valid;
  assign max_index = r_idx;
  assign max_val   = r_max;
  assign len_err   = r_len_err;
`ifdef ARGMAX_MARGIN_EN
  assign second_val = r_sec;
  assign margin     = r_margin;
`endif

endmodule
